// File: rtl/req_encoder_pkg.sv
// Shared widths and FSM state type for the request encoder slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package enc_pkg;
    localparam int REQ_W = 32;
    localparam int IDX_W = 5;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;
endpackage

// File: rtl/req_encoder_if.sv
// Request-in / index-out handshake bundle for req_encoder.
// Latency: n/a (wiring only).
// Backpressure: in_ready gates the producer, out_ready gates the encoder.
// Ports: in_valid/in_vec/in_ready (request side), out_valid/out_idx/out_last/out_ready
//        (index side), err (reject pulse). slave = encoder, master = producer/consumer.
interface req_encoder_if;
    import enc_pkg::*;

    logic             in_valid;
    logic [REQ_W-1:0] in_vec;
    logic             in_ready;
    logic             out_valid;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic             out_ready;
    logic             err;

    modport slave (
        input  in_valid, in_vec, out_ready,
        output in_ready, out_valid, out_idx, out_last, err
    );

    modport master (
        output in_valid, in_vec, out_ready,
        input  in_ready, out_valid, out_idx, out_last, err
    );
endinterface

// File: rtl/req_encoder_ffs32.sv
// Combinational find-first-set: lowest set bit index of a 32-bit vector.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: vec_i (input vector), idx_o (lowest set index, 0 when none),
//        found_o (any bit set), single_o (exactly one bit set).
module ffs32
    import enc_pkg::*;
(
    input  logic [REQ_W-1:0] vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o,
    output logic             single_o
);
    always_comb begin
        idx_o = '0;
        // Scan high to low so the last hit is the lowest set bit.
        for (int i = REQ_W - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
        found_o  = |vec_i;
        // Clearing the lowest set bit leaves zero only for a one-hot vector.
        single_o = found_o && ((vec_i & (vec_i - REQ_W'(1))) == '0);
    end
endmodule

// File: rtl/req_encoder.sv
// Drains an accepted request vector as ascending binary indices, one per transfer.
// Latency: first index 1 cycle after accept; back-to-back indices with no bubble.
// Backpressure: out_ready=0 holds out_idx/out_last; in_ready=0 while draining.
// Ports: clk, rst (async active-high), bus (req_encoder_if.slave).
// Build option: ONEHOT_CHECK_EN rejects vectors with more than one bit set.
module req_encoder
    import enc_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    req_encoder_if.slave  bus
);
    state_t           state_q, state_d;
    logic [REQ_W-1:0] pend_q, pend_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic             out_last_q, out_last_d;
    logic             err_q, err_d;

    logic             reject;
    logic [IDX_W-1:0] ffs_idx;
    logic             ffs_found;
    logic             ffs_single;

`ifdef ONEHOT_CHECK_EN
    assign reject = (bus.in_vec == '0) ||
                    ((bus.in_vec & (bus.in_vec - REQ_W'(1))) != '0);
`else
    assign reject = (bus.in_vec == '0);
`endif

    // Index and last flag are computed on the next pending value so they
    // can be registered alongside it, giving one-cycle accept latency.
    ffs32 u_ffs (
        .vec_i    (pend_d),
        .idx_o    (ffs_idx),
        .found_o  (ffs_found),
        .single_o (ffs_single)
    );

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (reject) begin
                        err_d = 1'b1;
                    end else begin
                        pend_d  = bus.in_vec;
                        state_d = EMIT;
                    end
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    // Drop the bit just served (the lowest set one).
                    pend_d = pend_q & (pend_q - REQ_W'(1));
                    if (out_last_q) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        out_idx_d  = ffs_found ? ffs_idx : '0;
        out_last_d = ffs_single;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            out_idx_q  <= '0;
            out_last_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            out_idx_q  <= out_idx_d;
            out_last_q <= out_last_d;
            err_q      <= err_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == EMIT);
    assign bus.out_idx   = out_idx_q;
    assign bus.out_last  = out_last_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_req_encoder.sv
// Randomized plus directed bench for req_encoder against a queue-of-indices model.
// Latency: checks outputs every cycle on the falling edge.
// Backpressure: random out_ready stalls exercise hold behaviour.
module tb_req_encoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    int   exp_q[$];
    logic err_exp = 1'b0;

    req_encoder_if bus ();

    req_encoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic model_reject(input logic [31:0] v);
`ifdef ONEHOT_CHECK_EN
        return ($countones(v) != 1);
`else
        return (v == 32'h0);
`endif
    endfunction

    // Check the current outputs against the model, then drive one cycle of
    // inputs and advance the model to what the DUT should show next cycle.
    task automatic step(input logic iv, input logic [31:0] v, input logic ordy);
        @(negedge clk);
        chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
        chk("in_ready",  32'(bus.in_ready),  32'(exp_q.size() == 0));
        chk("err",       32'(bus.err),       32'(err_exp));
        if (exp_q.size() != 0) begin
            chk("out_idx",  32'(bus.out_idx),  32'(exp_q[0]));
            chk("out_last", 32'(bus.out_last), 32'(exp_q.size() == 1));
        end
        bus.in_valid  = iv;
        bus.in_vec    = v;
        bus.out_ready = ordy;
        err_exp = 1'b0;
        if (exp_q.size() == 0) begin
            if (iv) begin
                if (model_reject(v)) begin
                    err_exp = 1'b1;
                end else begin
                    for (int i = 0; i < 32; i++) begin
                        if (v[i]) exp_q.push_back(i);
                    end
                end
            end
        end else if (ordy) begin
            void'(exp_q.pop_front());
        end
    endtask

    function automatic logic [31:0] rand_vec();
        logic [31:0] v;
        case ($urandom_range(0, 4))
            0:       v = 32'h0;
            1:       v = 32'h1 << $urandom_range(0, 31);
            2:       v = $urandom;
            3:       v = $urandom & $urandom & $urandom;
            default: v = 32'h8000_0001;
        endcase
        return v;
    endfunction

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_vec    = '0;
        bus.out_ready = 1'b0;

        // Reset state while held.
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_out_idx",   32'(bus.out_idx),   32'h0);
        chk("rst_out_last",  32'(bus.out_last),  32'h0);
        chk("rst_err",       32'(bus.err),       32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single bit 0.
        step(1'b1, 32'h0000_0001, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        // Zero vector reject.
        step(1'b1, 32'h0000_0000, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
`ifdef ONEHOT_CHECK_EN
        step(1'b1, 32'h0000_0300, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h0000_0200, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
`else
        step(1'b1, 32'h8000_0012, 1'b1);
        repeat (4) step(1'b0, 32'h0, 1'b1);
`endif
        // Stall hold, then drain; in_valid during EMIT must be ignored.
`ifndef ONEHOT_CHECK_EN
        step(1'b1, 32'h0000_00F0, 1'b0);
        repeat (5) step(1'b1, 32'hFFFF_0000, 1'b0);
        repeat (5) step(1'b0, 32'h0, 1'b1);

        // Reset mid-drain.
        step(1'b1, 32'hFFFF_FFFF, 1'b1);
        repeat (3) step(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("mid_rst_out_idx",   32'(bus.out_idx),   32'h0);
        chk("mid_rst_out_last",  32'(bus.out_last),  32'h0);
        chk("mid_rst_in_ready",  32'(bus.in_ready),  32'h1);
        exp_q.delete();
        err_exp = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) step(1'b0, 32'h0, 1'b1);
`endif

        // Randomized traffic with random backpressure.
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 1) == 1, rand_vec(), $urandom_range(0, 9) < 7);
        end
        // Drain whatever is left; 40 cycles covers a full 32-bit vector.
        repeat (40) step(1'b0, 32'h0, 1'b1);
        chk("drained", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
